// File: rtl/matrix_result_tx_framer_if.sv
// Bus between the result framer, the result buffer read port and the UART transmitter.
// Signal names follow the framer's port list; the buffer address width tracks MAX_SIZE.
interface matrix_result_tx_framer_if #(
    parameter int unsigned MAX_SIZE = 10
);
    localparam int unsigned ADDR_W = $clog2(MAX_SIZE * MAX_SIZE);

    logic              start;
    logic [7:0]        size;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;
    logic [7:0]        tx_byte;
    logic              tx_start;
    logic              tx_busy;
    logic              tx_done;
    logic              busy;
    logic              frame_done;
    logic              err;

    modport master (
        output start, size, rd_data, tx_busy, tx_done,
        input  rd_addr, tx_byte, tx_start, busy, frame_done, err
    );

    modport slave (
        input  start, size, rd_data, tx_busy, tx_done,
        output rd_addr, tx_byte, tx_start, busy, frame_done, err
    );
endinterface

// File: rtl/matrix_result_tx_framer.sv
// Frames an N x N matrix of 16-bit results as A5, N, {hi,lo}* bytes for a UART transmitter.
// Define MATRIX_TX_CHECKSUM_EN to append an XOR checksum of every sent byte to each frame.
module matrix_result_tx_framer #(
    parameter int unsigned MAX_SIZE   = 10,
    parameter int unsigned GAP_CYCLES = 12500,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input logic clk,
    input logic rst_n,
    matrix_result_tx_framer_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(MAX_SIZE * MAX_SIZE);
    localparam int unsigned GAP_W  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_DONE, GAP, FETCH, LOAD, FINISH
`ifdef MATRIX_TX_CHECKSUM_EN
        , CKSUM
`endif
    } state_e;

    // Which byte was handed to the transmitter last; decides the next one after the gap.
    typedef enum logic [2:0] {PH_HDR, PH_SIZE, PH_HI, PH_LO, PH_CK} phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        total_q, total_d;
    logic [7:0]        idx_q, idx_d;
    logic [15:0]       word_q, word_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_start_q, tx_start_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;
    logic              busy_s1_q, busy_s2_q;
    logic              done_s1_q, done_s2_q, done_s3_q;
`ifdef MATRIX_TX_CHECKSUM_EN
    logic [7:0]        cksum_q, cksum_d;
`endif

    logic size_ok_c;
    logic done_edge_c;

    assign size_ok_c   = (bus.size >= 8'd2) && (bus.size <= 8'(MAX_SIZE));
    assign done_edge_c = done_s2_q & ~done_s3_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        n_d          = n_q;
        total_d      = total_q;
        idx_d        = idx_q;
        word_d       = word_q;
        gap_d        = gap_q;
        tx_byte_d    = tx_byte_q;
        rd_addr_d    = rd_addr_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
`ifdef MATRIX_TX_CHECKSUM_EN
        cksum_d      = cksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (size_ok_c) begin
                        n_d       = bus.size;
                        total_d   = 8'(bus.size * bus.size);
                        idx_d     = 8'd0;
                        busy_d    = 1'b1;
                        tx_byte_d = HEADER;
                        phase_d   = PH_HDR;
`ifdef MATRIX_TX_CHECKSUM_EN
                        cksum_d   = 8'd0;
`endif
                        state_d   = SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (busy_s2_q) begin
`ifdef MATRIX_TX_CHECKSUM_EN
                    cksum_d = cksum_q ^ tx_byte_q;
`endif
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_edge_c) begin
                    gap_d   = GAP_W'(GAP_CYCLES);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q > GAP_W'(1)) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    gap_d = '0;
                    case (phase_q)
                        PH_HDR: begin
                            tx_byte_d = n_q;
                            phase_d   = PH_SIZE;
                            state_d   = SEND;
                        end
                        PH_SIZE: begin
                            rd_addr_d = ADDR_W'(idx_q);
                            state_d   = FETCH;
                        end
                        PH_HI: begin
                            tx_byte_d = word_q[7:0];
                            phase_d   = PH_LO;
                            state_d   = SEND;
                        end
                        PH_LO: begin
                            if (idx_q == total_q - 8'd1) begin
`ifdef MATRIX_TX_CHECKSUM_EN
                                state_d = CKSUM;
`else
                                state_d = FINISH;
`endif
                            end else begin
                                idx_d     = idx_q + 8'd1;
                                rd_addr_d = ADDR_W'(idx_q + 8'd1);
                                state_d   = FETCH;
                            end
                        end
                        default: state_d = FINISH;
                    endcase
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                word_d    = bus.rd_data;
                tx_byte_d = bus.rd_data[15:8];
                phase_d   = PH_HI;
                state_d   = SEND;
            end
`ifdef MATRIX_TX_CHECKSUM_EN
            CKSUM: begin
                tx_byte_d = cksum_q;
                phase_d   = PH_CK;
                state_d   = SEND;
            end
`endif
            FINISH: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        tx_start_d = (state_d == SEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= PH_HDR;
            n_q          <= 8'd0;
            total_q      <= 8'd0;
            idx_q        <= 8'd0;
            word_q       <= 16'd0;
            gap_q        <= '0;
            tx_byte_q    <= 8'd0;
            tx_start_q   <= 1'b0;
            rd_addr_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            busy_s1_q    <= 1'b0;
            busy_s2_q    <= 1'b0;
            done_s1_q    <= 1'b0;
            done_s2_q    <= 1'b0;
            done_s3_q    <= 1'b0;
`ifdef MATRIX_TX_CHECKSUM_EN
            cksum_q      <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            n_q          <= n_d;
            total_q      <= total_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            gap_q        <= gap_d;
            tx_byte_q    <= tx_byte_d;
            tx_start_q   <= tx_start_d;
            rd_addr_q    <= rd_addr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            busy_s1_q    <= bus.tx_busy;
            busy_s2_q    <= busy_s1_q;
            done_s1_q    <= bus.tx_done;
            done_s2_q    <= done_s1_q;
            done_s3_q    <= done_s2_q;
`ifdef MATRIX_TX_CHECKSUM_EN
            cksum_q      <= cksum_d;
`endif
        end
    end

    assign bus.tx_byte    = tx_byte_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;
endmodule
